load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response/memory bundle for the load/store unit.
// The slave modport is the unit's view; master is the core-and-memory side.
interface load_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            funct3;
  logic [31:0]           base;
  logic [31:0]           offset;
  logic [31:0]           store_data;
  logic [4:0]            rd;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [4:0]            resp_rd;
  logic                  resp_fault;

  logic                  mem_wren;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_data_in;
  logic [31:0]           mem_data_out;

  modport slave (
    input  req_valid, req_write, funct3, base, offset, store_data, rd,
    input  resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_data, resp_rd, resp_fault,
    output mem_wren, mem_funct3, mem_address, mem_data_in
  );

  modport master (
    output req_valid, req_write, funct3, base, offset, store_data, rd,
    output resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_fault,
    input  mem_wren, mem_funct3, mem_address, mem_data_in
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one request, issues one memory
// cycle (or faults locally), and holds the response until it is consumed.
module load_store_unit #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned CHECK_ALIGN = 1,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_q;
  logic [4:0]       rd_q;

  logic [31:0]      ea_c;
  logic             illegal_c;
  logic             misaligned_c;
  logic             fault_c;

  // Request decode, evaluated against the live inputs at the acceptance edge
  always_comb begin
    ea_c         = bus.base + bus.offset;
    illegal_c    = 1'b0;
    misaligned_c = 1'b0;
    if (bus.req_write) begin
      illegal_c = (bus.funct3 >= 3'b011);
    end else begin
      illegal_c = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                  (bus.funct3 == 3'b111);
    end
    if (bus.funct3[1:0] == 2'b01) begin
      misaligned_c = ea_c[0];
    end else if (bus.funct3 == 3'b010) begin
      misaligned_c = (ea_c[1:0] != 2'b00);
    end
    fault_c = (CHECK_ALIGN != 0) && (illegal_c || misaligned_c);
  end

  // Control FSM with registered handshake, response and memory outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      wr_q            <= 1'b0;
      rd_q            <= '0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_data   <= '0;
      bus.resp_rd     <= '0;
      bus.resp_fault  <= 1'b0;
      bus.mem_wren    <= 1'b0;
      bus.mem_funct3  <= '0;
      bus.mem_address <= '0;
      bus.mem_data_in <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            wr_q          <= bus.req_write;
            rd_q          <= bus.rd;
            bus.req_ready <= 1'b0;
            if (fault_c) begin
              state_q        <= S_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_fault <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_rd    <= '0;
            end else begin
              // Memory outputs are loaded here so they are live during ACCESS
              state_q         <= S_ACCESS;
              bus.mem_wren    <= bus.req_write;
              bus.mem_funct3  <= bus.funct3;
              bus.mem_address <= ea_c[ADDR_WIDTH-1:0];
              bus.mem_data_in <= bus.store_data;
            end
          end
        end

        S_ACCESS: begin
          bus.mem_wren <= 1'b0;
          if (wr_q) begin
            state_q        <= S_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= '0;
            bus.resp_rd    <= '0;
            bus.resp_fault <= 1'b0;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
          end
        end

        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q        <= S_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= bus.mem_data_out;
            bus.resp_rd    <= rd_q;
            bus.resp_fault <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_RESP: begin
          if (bus.resp_ready) begin
            state_q        <= S_IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: three instances cover latency 1 with and
// without local alignment checks, and latency 4 with backpressure and reset.
module tb_load_store_unit;
  logic clk;
  logic reset;

  logic        t_valid [3];
  logic        t_ready [3];
  logic        t_write;
  logic [2:0]  t_funct3;
  logic [31:0] t_base;
  logic [31:0] t_offset;
  logic [31:0] t_sdata;
  logic [4:0]  t_rd;
  logic [31:0] t_mdata;

  int n_cmp;
  int n_err;
  int sel;

  load_store_unit_if #(.ADDR_WIDTH(32)) ifa ();
  load_store_unit_if #(.ADDR_WIDTH(32)) ifb ();
  load_store_unit_if #(.ADDR_WIDTH(32)) ifc ();

  load_store_unit #(.MEM_LATENCY(1), .CHECK_ALIGN(1), .ADDR_WIDTH(32))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  load_store_unit #(.MEM_LATENCY(1), .CHECK_ALIGN(0), .ADDR_WIDTH(32))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  load_store_unit #(.MEM_LATENCY(4), .CHECK_ALIGN(1), .ADDR_WIDTH(32))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  // Shared request fields; valid/ready are per instance
  assign ifa.req_valid = t_valid[0];
  assign ifb.req_valid = t_valid[1];
  assign ifc.req_valid = t_valid[2];
  assign ifa.resp_ready = t_ready[0];
  assign ifb.resp_ready = t_ready[1];
  assign ifc.resp_ready = t_ready[2];
  assign ifa.req_write = t_write;  assign ifb.req_write = t_write;  assign ifc.req_write = t_write;
  assign ifa.funct3 = t_funct3;    assign ifb.funct3 = t_funct3;    assign ifc.funct3 = t_funct3;
  assign ifa.base = t_base;        assign ifb.base = t_base;        assign ifc.base = t_base;
  assign ifa.offset = t_offset;    assign ifb.offset = t_offset;    assign ifc.offset = t_offset;
  assign ifa.store_data = t_sdata; assign ifb.store_data = t_sdata; assign ifc.store_data = t_sdata;
  assign ifa.rd = t_rd;            assign ifb.rd = t_rd;            assign ifc.rd = t_rd;
  assign ifa.mem_data_out = t_mdata;
  assign ifb.mem_data_out = t_mdata;
  assign ifc.mem_data_out = t_mdata;

  logic        v_req_ready, v_resp_valid, v_resp_fault, v_mem_wren;
  logic [31:0] v_resp_data, v_mem_address, v_mem_data_in;
  logic [4:0]  v_resp_rd;
  logic [2:0]  v_mem_funct3;

  always_comb begin
    case (sel)
      0: begin
        v_req_ready = ifa.req_ready;   v_resp_valid = ifa.resp_valid;
        v_resp_data = ifa.resp_data;   v_resp_rd = ifa.resp_rd;
        v_resp_fault = ifa.resp_fault; v_mem_wren = ifa.mem_wren;
        v_mem_funct3 = ifa.mem_funct3; v_mem_address = ifa.mem_address;
        v_mem_data_in = ifa.mem_data_in;
      end
      1: begin
        v_req_ready = ifb.req_ready;   v_resp_valid = ifb.resp_valid;
        v_resp_data = ifb.resp_data;   v_resp_rd = ifb.resp_rd;
        v_resp_fault = ifb.resp_fault; v_mem_wren = ifb.mem_wren;
        v_mem_funct3 = ifb.mem_funct3; v_mem_address = ifb.mem_address;
        v_mem_data_in = ifb.mem_data_in;
      end
      default: begin
        v_req_ready = ifc.req_ready;   v_resp_valid = ifc.resp_valid;
        v_resp_data = ifc.resp_data;   v_resp_rd = ifc.resp_rd;
        v_resp_fault = ifc.resp_fault; v_mem_wren = ifc.mem_wren;
        v_mem_funct3 = ifc.mem_funct3; v_mem_address = ifc.mem_address;
        v_mem_data_in = ifc.mem_data_in;
      end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request to instance s; it is accepted at the next edge
  task automatic issue(input int s, input logic w, input logic [2:0] f3,
                       input logic [31:0] b, input logic [31:0] o,
                       input logic [31:0] sd, input logic [4:0] r);
    sel = s;
    t_write = w; t_funct3 = f3; t_base = b; t_offset = o; t_sdata = sd; t_rd = r;
    t_valid[s] = 1'b1;
    tick();
    t_valid[s] = 1'b0;
  endtask

  task automatic consume(input int s);
    t_ready[s] = 1'b1;
    tick();
    t_ready[s] = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      t_valid[i] = 1'b0;
      t_ready[i] = 1'b0;
    end
    t_write = 1'b0; t_funct3 = 3'b000; t_base = '0; t_offset = '0;
    t_sdata = '0; t_rd = '0; t_mdata = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    check("rst_req_ready", 32'(v_req_ready), 32'd1);
    check("rst_resp_valid", 32'(v_resp_valid), 32'd0);
    check("rst_mem_wren", 32'(v_mem_wren), 32'd0);
    check("rst_mem_address", v_mem_address, 32'h0);
    check("rst_resp_data", v_resp_data, 32'h0);

    // lw 0x100+4, latency 1
    t_mdata = 32'hDEADBEEF;
    issue(0, 1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5);
    check("lw_access_addr", v_mem_address, 32'h104);
    check("lw_access_f3", 32'(v_mem_funct3), 32'd2);
    check("lw_access_wren", 32'(v_mem_wren), 32'd0);
    check("lw_access_req_ready", 32'(v_req_ready), 32'd0);
    tick();
    check("lw_edge2_valid", 32'(v_resp_valid), 32'd0);
    tick();
    check("lw_edge3_valid", 32'(v_resp_valid), 32'd1);
    check("lw_data", v_resp_data, 32'hDEADBEEF);
    check("lw_rd", 32'(v_resp_rd), 32'd5);
    check("lw_fault", 32'(v_resp_fault), 32'd0);
    // Request while busy is ignored
    issue(0, 1'b1, 3'b010, 32'h300, 32'h0, 32'h55, 5'd9);
    check("busy_ignored_rd", 32'(v_resp_rd), 32'd5);
    check("busy_ignored_wren", 32'(v_mem_wren), 32'd0);
    consume(0);
    check("lw_consumed_valid", 32'(v_resp_valid), 32'd0);
    check("lw_consumed_req_ready", 32'(v_req_ready), 32'd1);

    // sb 0x200-1
    issue(0, 1'b1, 3'b000, 32'h200, 32'hFFFF_FFFF, 32'h0000_00AB, 5'd7);
    check("sb_wren", 32'(v_mem_wren), 32'd1);
    check("sb_addr", v_mem_address, 32'h1FF);
    check("sb_f3", 32'(v_mem_funct3), 32'd0);
    check("sb_wdata", v_mem_data_in, 32'hAB);
    check("sb_early_valid", 32'(v_resp_valid), 32'd0);
    tick();
    check("sb_wren_drop", 32'(v_mem_wren), 32'd0);
    check("sb_valid", 32'(v_resp_valid), 32'd1);
    check("sb_data", v_resp_data, 32'h0);
    check("sb_rd", 32'(v_resp_rd), 32'd0);
    check("sb_addr_hold", v_mem_address, 32'h1FF);
    consume(0);
    tick();

    // Misaligned lh faults locally
    issue(0, 1'b0, 3'b001, 32'h100, 32'h1, 32'h0, 5'd4);
    check("lh_mis_valid", 32'(v_resp_valid), 32'd1);
    check("lh_mis_fault", 32'(v_resp_fault), 32'd1);
    check("lh_mis_wren", 32'(v_mem_wren), 32'd0);
    check("lh_mis_rd", 32'(v_resp_rd), 32'd0);
    check("lh_mis_addr_hold", v_mem_address, 32'h1FF);
    consume(0);
    tick();

    // Illegal load funct3 011
    issue(0, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd3);
    check("ld011_fault", 32'(v_resp_fault), 32'd1);
    check("ld011_wren", 32'(v_mem_wren), 32'd0);
    consume(0);
    tick();

    // Illegal store funct3 100
    issue(0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 5'd3);
    check("st100_fault", 32'(v_resp_fault), 32'd1);
    check("st100_wren", 32'(v_mem_wren), 32'd0);
    check("st100_data", v_resp_data, 32'h0);
    consume(0);
    tick();

    // Wrap-around address is legal
    t_mdata = 32'h0BAD_F00D;
    issue(0, 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd11);
    check("wrap_addr", v_mem_address, 32'h4);
    check("wrap_no_fault_yet", 32'(v_resp_valid), 32'd0);
    tick();
    tick();
    check("wrap_valid", 32'(v_resp_valid), 32'd1);
    check("wrap_fault", 32'(v_resp_fault), 32'd0);
    check("wrap_data", v_resp_data, 32'h0BAD_F00D);
    consume(0);
    tick();

    // Misaligned lh forwarded when checks are off
    t_mdata = 32'hFFFF_8001;
    issue(1, 1'b0, 3'b001, 32'h100, 32'h1, 32'h0, 5'd12);
    check("lh_nochk_addr", v_mem_address, 32'h101);
    check("lh_nochk_f3", 32'(v_mem_funct3), 32'd1);
    check("lh_nochk_early", 32'(v_resp_valid), 32'd0);
    tick();
    tick();
    check("lh_nochk_valid", 32'(v_resp_valid), 32'd1);
    check("lh_nochk_fault", 32'(v_resp_fault), 32'd0);
    check("lh_nochk_data", v_resp_data, 32'hFFFF_8001);
    check("lh_nochk_rd", 32'(v_resp_rd), 32'd12);
    consume(1);
    tick();

    // Latency 4 with backpressure
    t_mdata = 32'h1234_5678;
    issue(2, 1'b0, 3'b010, 32'h40, 32'h10, 32'h0, 5'd3);
    check("l4_addr", v_mem_address, 32'h50);
    for (int i = 0; i < 4; i++) tick();
    check("l4_edge5_valid", 32'(v_resp_valid), 32'd0);
    tick();
    check("l4_edge6_valid", 32'(v_resp_valid), 32'd1);
    check("l4_data", v_resp_data, 32'h1234_5678);
    t_mdata = 32'hAAAA_5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("l4_hold_data", v_resp_data, 32'h1234_5678);
      check("l4_hold_valid", 32'(v_resp_valid), 32'd1);
      check("l4_hold_req_ready", 32'(v_req_ready), 32'd0);
    end
    consume(2);
    check("l4_release_req_ready", 32'(v_req_ready), 32'd1);
    check("l4_release_valid", 32'(v_resp_valid), 32'd0);
    tick();

    // Reset during WAIT aborts the load
    issue(2, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd6);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_req_ready", 32'(v_req_ready), 32'd1);
    check("abort_valid", 32'(v_resp_valid), 32'd0);
    check("abort_wren", 32'(v_mem_wren), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_no_resp", 32'(v_resp_valid), 32'd0);

    // sw after abort completes normally
    issue(2, 1'b1, 3'b010, 32'h80, 32'h0, 32'hCAFE_F00D, 5'd1);
    check("sw_wren", 32'(v_mem_wren), 32'd1);
    check("sw_addr", v_mem_address, 32'h80);
    check("sw_wdata", v_mem_data_in, 32'hCAFE_F00D);
    tick();
    check("sw_valid", 32'(v_resp_valid), 32'd1);
    check("sw_fault", 32'(v_resp_fault), 32'd0);
    check("sw_data", v_resp_data, 32'h0);
    consume(2);
    check("sw_done_req_ready", 32'(v_req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
